// File: rtl/sopc_timer.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and level interrupt.
// Sits on the openmips_min_sopc data bus; everything runs in the core clock domain.
module sopc_timer #(
    parameter int unsigned PRESCALE_W = 8,
    parameter logic [31:0] RESET_LOAD = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        int_o
);

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_LOAD   = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    logic                  en_q, en_d;
    logic                  auto_q, auto_d;
    logic                  ie_q, ie_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [31:0]           load_q, load_d;
    logic [31:0]           count_q, count_d;
    logic                  pend_q, pend_d;

    reg_e        reg_sel;
    logic        bus_wr;
    logic        ctrl_wr;
    logic        load_wr;
    logic        status_clr;
    logic        tick;
    logic        expire;
    logic [31:0] ctrl_rd;
    logic [31:0] ctrl_new;
    logic        unused_addr;

    assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        ctrl_rd                 = '0;
        ctrl_rd[2:0]            = {ie_q, auto_q, en_q};
        ctrl_rd[8 +: PRESCALE_W] = prescale_q;
    end

    always_comb begin
        reg_sel    = reg_e'(addr_i[3:2]);
        bus_wr     = ce_i & we_i & (|sel_i);
        ctrl_wr    = bus_wr & (reg_sel == REG_CTRL);
        load_wr    = bus_wr & (reg_sel == REG_LOAD);
        status_clr = bus_wr & (reg_sel == REG_STATUS) & sel_i[0] & data_i[0];
        ctrl_new   = merge_lanes(ctrl_rd, data_i, sel_i);
        tick       = en_q & (pre_cnt_q == prescale_q);
        // A LOAD write suppresses the whole tick, including expiry side effects.
        expire     = tick & ~load_wr & (count_q == '0);
    end

    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        ie_d       = ie_q;
        prescale_d = prescale_q;
        load_d     = load_q;
        count_d    = count_q;
        pend_d     = pend_q;
        pre_cnt_d  = pre_cnt_q;

        if (ctrl_wr) begin
            en_d       = ctrl_new[0];
            auto_d     = ctrl_new[1];
            ie_d       = ctrl_new[2];
            prescale_d = ctrl_new[8 +: PRESCALE_W];
        end else if (expire && !auto_q) begin
            en_d = 1'b0;
        end

        if (load_wr) begin
            load_d  = merge_lanes(load_q, data_i, sel_i);
            count_d = load_d;
        end else if (tick) begin
            if (count_q != '0) count_d = count_q - 32'd1;
            else if (auto_q)   count_d = load_q;
        end

        pend_d = expire | (pend_q & ~status_clr);

        if (!en_d || load_wr || tick || (ctrl_wr && !en_q)) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            ie_q       <= 1'b0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            load_q     <= RESET_LOAD;
            count_q    <= RESET_LOAD;
            pend_q     <= 1'b0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            ie_q       <= ie_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            load_q     <= load_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        data_o = '0;
        if (ce_i && !we_i) begin
            unique case (reg_sel)
                REG_CTRL:   data_o = ctrl_rd;
                REG_LOAD:   data_o = load_q;
                REG_COUNT:  data_o = count_q;
                REG_STATUS: data_o = {31'd0, pend_q};
                default:    data_o = '0;
            endcase
        end
    end

    assign int_o = pend_q & ie_q;

endmodule

// File: tb/tb_sopc_timer.sv
// Self-checking bench for sopc_timer: bus reads queue their expected value, which is
// popped and compared once the combinational read data has settled.
module tb_sopc_timer;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LOAD   = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        int_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    sopc_timer #(.PRESCALE_W(8), .RESET_LOAD(32'h0)) dut (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (ce_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .sel_i  (sel_i),
        .data_i (data_i),
        .data_o (data_o),
        .int_o  (int_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the write commits at the following rising edge.
    task automatic bus_wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
        ce_i   = 1'b1;
        we_i   = 1'b1;
        addr_i = {28'd0, r, 2'b00};
        data_i = d;
        sel_i  = s;
        @(negedge clk);
        ce_i   = 1'b0;
        we_i   = 1'b0;
        sel_i  = '0;
    endtask

    task automatic bus_rd(input logic [1:0] r, input logic [31:0] exp, input string tag,
                          input logic ce);
        logic [31:0] e;
        string       t;
        ce_i   = ce;
        we_i   = 1'b0;
        addr_i = {28'd0, r, 2'b00};
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, data_o, e);
        end
        ce_i = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(2);
        rst = 1'b1;
        idle(1);

        bus_rd(A_CTRL,   32'h0, "rst_ctrl",   1'b1);
        bus_rd(A_LOAD,   32'h0, "rst_load",   1'b1);
        bus_rd(A_COUNT,  32'h0, "rst_count",  1'b1);
        bus_rd(A_STATUS, 32'h0, "rst_status", 1'b1);
        check_eq("rst_int", {31'd0, int_o}, 32'd0);

        // Undefined CTRL bits read 0; sel_i = 0 writes nothing.
        bus_wr(A_CTRL, 32'hFFFF_FFF8, 4'hF);
        bus_rd(A_CTRL, 32'h0000_FF00, "ctrl_mask", 1'b1);
        bus_wr(A_CTRL, 32'hFFFF_FFFF, 4'h0);
        bus_rd(A_CTRL, 32'h0000_FF00, "ctrl_sel0", 1'b1);
        bus_wr(A_CTRL, 32'h0, 4'hF);

        // Auto-reload, LOAD = 4, PRESCALE = 0: expiry every 5 cycles.
        bus_wr(A_LOAD, 32'd4, 4'hF);
        bus_wr(A_CTRL, 32'h7, 4'hF);
        idle(4);
        check_eq("auto_int_pre", {31'd0, int_o}, 32'd0);
        bus_rd(A_COUNT, 32'd0, "auto_count0", 1'b1);
        idle(1);
        check_eq("auto_int_rise", {31'd0, int_o}, 32'd1);
        bus_rd(A_COUNT,  32'd4, "auto_reload", 1'b1);
        bus_rd(A_STATUS, 32'd1, "auto_pend",   1'b1);
        bus_wr(A_STATUS, 32'h1, 4'h1);
        check_eq("auto_clr_int", {31'd0, int_o}, 32'd0);
        bus_rd(A_COUNT, 32'd3, "auto_dec", 1'b1);
        idle(3);
        check_eq("auto_int_pre2", {31'd0, int_o}, 32'd0);
        bus_rd(A_COUNT, 32'd0, "auto_count0b", 1'b1);
        idle(1);
        check_eq("auto_int_rise2", {31'd0, int_o}, 32'd1);

        // Clear on the exact expiry cycle: set wins; the next clear drops int_o.
        idle(4);
        bus_wr(A_STATUS, 32'h1, 4'h1);
        check_eq("clr_race_int", {31'd0, int_o}, 32'd1);
        bus_rd(A_STATUS, 32'd1, "clr_race_pend", 1'b1);
        bus_wr(A_STATUS, 32'h1, 4'h1);
        check_eq("clr2_int", {31'd0, int_o}, 32'd0);
        bus_rd(A_STATUS, 32'd0, "clr2_pend", 1'b1);
        idle(4);
        check_eq("auto_int_rise3", {31'd0, int_o}, 32'd1);

        // Asynchronous reset mid-run.
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_int", {31'd0, int_o}, 32'd0);
        bus_rd(A_CTRL,   32'h0, "async_ctrl",   1'b1);
        bus_rd(A_LOAD,   32'h0, "async_load",   1'b1);
        bus_rd(A_COUNT,  32'h0, "async_count",  1'b1);
        bus_rd(A_STATUS, 32'h0, "async_status", 1'b1);
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        bus_rd(A_STATUS, 32'h0, "post_rst_status", 1'b1);

        // One-shot, LOAD = 2, PRESCALE = 3: expiry 12 cycles after EN.
        bus_wr(A_LOAD, 32'd2, 4'hF);
        bus_wr(A_CTRL, 32'h0305, 4'hF);
        idle(11);
        bus_rd(A_STATUS, 32'd0,      "os_pend_pre", 1'b1);
        bus_rd(A_CTRL,   32'h0305,   "os_ctrl_pre", 1'b1);
        bus_rd(A_COUNT,  32'd0,      "os_count_pre", 1'b1);
        idle(1);
        bus_rd(A_STATUS, 32'd1,      "os_pend", 1'b1);
        bus_rd(A_CTRL,   32'h0304,   "os_en_off", 1'b1);
        check_eq("os_int", {31'd0, int_o}, 32'd1);
        idle(8);
        bus_rd(A_COUNT,  32'd0,      "os_count_hold", 1'b1);

        // IE = 0 masks int_o but keeps PEND.
        bus_wr(A_CTRL, 32'h0300, 4'hF);
        check_eq("ie_mask_int", {31'd0, int_o}, 32'd0);
        bus_rd(A_STATUS, 32'd1, "ie_mask_pend", 1'b1);

        // COUNT is read-only; reads with ce_i = 0 return 0.
        bus_wr(A_LOAD, 32'd7, 4'hF);
        bus_wr(A_COUNT, 32'h0000_FFFF, 4'hF);
        bus_rd(A_COUNT, 32'd7, "count_ro", 1'b1);
        bus_rd(A_COUNT, 32'd0, "ce_off_read", 1'b0);

        // Partial LOAD write while running overrides the decrement.
        bus_wr(A_LOAD, 32'h1234_5600, 4'hF);
        bus_wr(A_CTRL, 32'h3, 4'hF);
        idle(2);
        bus_rd(A_COUNT, 32'h1234_55FE, "run_count", 1'b1);
        bus_wr(A_LOAD, 32'h0000_0009, 4'h1);
        bus_rd(A_LOAD,  32'h1234_5609, "lane_load",  1'b1);
        bus_rd(A_COUNT, 32'h1234_5609, "lane_count", 1'b1);
        idle(1);
        bus_rd(A_COUNT, 32'h1234_5608, "lane_dec", 1'b1);
        check_eq("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
